// File: rtl/spi_reg_controller.sv
// SPI mode-0 controller issuing 16-bit {rw, addr[6:0], data[7:0]} frames, MSB first.
// Optional SPI_READ_EN: rw=0 frames capture cipo during the data byte into rsp_data.
module spi_reg_controller #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo
);

    localparam int unsigned MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'((CS_IDLE > 0) ? CS_IDLE - 1 : 0);
    localparam logic [4:0]       LAST_BIT   = 5'd15;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       bit_cnt, bit_nxt;
    logic [14:0]      sh, sh_nxt;
    logic             ready_nxt, rsp_valid_nxt, sclk_nxt, copi_nxt, ncs_nxt;
    logic [7:0]       rsp_data_nxt;
    logic             frame_msb;

`ifdef SPI_READ_EN
    logic       rw, rw_nxt;
    logic [7:0] rx, rx_nxt;
    assign frame_msb = req_rw;
`else
    logic unused_in;
    assign unused_in = ^{req_rw, cipo};
    assign frame_msb = 1'b1;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
`ifdef SPI_READ_EN
            rw        <= 1'b1;
            rx        <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_nxt;
            sh        <= sh_nxt;
            req_ready <= ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            sclk      <= sclk_nxt;
            copi      <= copi_nxt;
            ncs       <= ncs_nxt;
`ifdef SPI_READ_EN
            rw        <= rw_nxt;
            rx        <= rx_nxt;
`endif
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_nxt       = bit_cnt;
        sh_nxt        = sh;
        ready_nxt     = req_ready;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        sclk_nxt      = sclk;
        copi_nxt      = copi;
        ncs_nxt       = ncs;
`ifdef SPI_READ_EN
        rw_nxt        = rw;
        rx_nxt        = rx;
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    sh_nxt    = {req_addr, req_data};
                    ready_nxt = 1'b0;
                    ncs_nxt   = 1'b0;
                    sclk_nxt  = 1'b0;
                    copi_nxt  = frame_msb;
`ifdef SPI_READ_EN
                    rw_nxt    = req_rw;
                    rx_nxt    = '0;
`endif
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    sclk_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt != DIV_LAST) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                    if (sclk) begin
                        // Falling edge: advance copi, except after bit0 which holds into HOLD
                        sclk_nxt = 1'b0;
                        if (bit_cnt != LAST_BIT) begin
                            copi_nxt = sh[14];
                            sh_nxt   = {sh[13:0], 1'b0};
                        end
`ifdef SPI_READ_EN
                        if (bit_cnt >= 5'd8) begin
                            rx_nxt = {rx[6:0], cipo};
                        end
`endif
                    end else begin
                        bit_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = HOLD;
                        end else begin
                            sclk_nxt = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt       = '0;
                    ncs_nxt       = 1'b1;
                    copi_nxt      = 1'b0;
                    rsp_valid_nxt = 1'b1;
`ifdef SPI_READ_EN
                    rsp_data_nxt  = rw ? 8'h00 : rx;
`endif
                    if (CS_IDLE == 0) begin
                        state_nxt = IDLE;
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == IDLE_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
